// File: rtl/calc_entry_sequencer.sv
// calc_entry_sequencer
// Steps the user through the entry of a two-operand 4-bit add/subtract:
// A0 -> op -> A1 -> result. Key inputs are synchronized and debounced.
// Switch inputs are synchronized only. All outputs come straight from flops.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   sw[3:0], sw_op    operand / op switches (asynchronous)
//   key_next_n        "next" pushbutton, active-low, bouncing
//   key_clr_n         "clear" pushbutton, active-low, bouncing
//   a0, a1, op_sub    operand and op values for HEX5 / HEX3 / HEX4
//   res_mag, res_neg  result magnitude (0..30) and sign
//   result_valid      high only while the result is shown
//   blank_mask[5:0]   bit i = 1 blanks HEXi; the field being edited blinks
//   state_o[1:0]      current state for debug LEDs
module calc_entry_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned BLINK_DIV       = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       sw_op,
  input  logic       key_next_n,
  input  logic       key_clr_n,
  output logic [3:0] a0,
  output logic [3:0] a1,
  output logic       op_sub,
  output logic [4:0] res_mag,
  output logic       res_neg,
  output logic       result_valid,
  output logic [5:0] blank_mask,
  output logic [1:0] state_o
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned BL_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned K_NEXT = 0;
  localparam int unsigned K_CLR  = 1;

  typedef enum logic [1:0] {
    ENTER_A0    = 2'd0,
    ENTER_OP    = 2'd1,
    ENTER_A1    = 2'd2,
    SHOW_RESULT = 2'd3
  } state_t;

  logic [3:0]      r_sw_s1, r_sw_s2;
  logic            r_op_s1, r_op_s2;
  logic [1:0]      r_key_s1, r_key_s2, r_key_lvl, r_key_evt;
  logic [DB_W-1:0] r_db_cnt [2];

  state_t          r_state;
  logic [3:0]      r_a0, r_a1;
  logic            r_op_sub, r_res_neg, r_result_valid;
  logic [4:0]      r_res_mag;
  logic [5:0]      r_blank_mask;
  logic [BL_W-1:0] r_blink_cnt;
  logic            r_blink_phase;

  logic [4:0]      w_sum, w_diff_fwd, w_diff_rev;
  logic            w_a0_ge;

  // Blank pattern for a state: result digits off while editing, active field blinks
  function automatic logic [5:0] f_mask(input state_t s, input logic ph);
    case (s)
      ENTER_A0: f_mask = {ph, 5'b00111};
      ENTER_OP: f_mask = {1'b0, ph, 4'b0111};
      ENTER_A1: f_mask = {2'b00, ph, 3'b111};
      default:  f_mask = 6'b000000;
    endcase
  endfunction

  // Switch synchronizers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_s1 <= 4'd0;
      r_sw_s2 <= 4'd0;
      r_op_s1 <= 1'b0;
      r_op_s2 <= 1'b0;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
      r_op_s1 <= sw_op;
      r_op_s2 <= r_op_s1;
    end
  end

  // Key synchronizers and debouncers; a press pulse fires when the accepted level falls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_s1  <= 2'b11;
      r_key_s2  <= 2'b11;
      r_key_lvl <= 2'b11;
      r_key_evt <= 2'b00;
      for (int k = 0; k < 2; k++) r_db_cnt[k] <= '0;
    end else begin
      r_key_s1 <= {key_clr_n, key_next_n};
      r_key_s2 <= r_key_s1;
      for (int k = 0; k < 2; k++) begin
        r_key_evt[k] <= 1'b0;
        if (r_key_s2[k] == r_key_lvl[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_key_lvl[k] <= r_key_s2[k];
          r_db_cnt[k]  <= '0;
          r_key_evt[k] <= ~r_key_s2[k];
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  // Result candidates using held a0 and the a1 being latched this cycle
  assign w_sum      = {1'b0, r_a0} + {1'b0, r_sw_s2};
  assign w_diff_fwd = {1'b0, r_a0} - {1'b0, r_sw_s2};
  assign w_diff_rev = {1'b0, r_sw_s2} - {1'b0, r_a0};
  assign w_a0_ge    = (r_a0 >= r_sw_s2);

  // Entry state machine with blink timer; every state change restarts the blink
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ENTER_A0;
      r_a0           <= 4'd0;
      r_a1           <= 4'd0;
      r_op_sub       <= 1'b0;
      r_res_mag      <= 5'd0;
      r_res_neg      <= 1'b0;
      r_result_valid <= 1'b0;
      r_blank_mask   <= 6'b000111;
      r_blink_cnt    <= '0;
      r_blink_phase  <= 1'b0;
    end else if (r_key_evt[K_CLR]) begin
      r_state        <= ENTER_A0;
      r_a0           <= 4'd0;
      r_a1           <= 4'd0;
      r_op_sub       <= 1'b0;
      r_res_mag      <= 5'd0;
      r_res_neg      <= 1'b0;
      r_result_valid <= 1'b0;
      r_blank_mask   <= f_mask(ENTER_A0, 1'b0);
      r_blink_cnt    <= '0;
      r_blink_phase  <= 1'b0;
    end else if (r_key_evt[K_NEXT]) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      case (r_state)
        ENTER_A0: begin
          r_state      <= ENTER_OP;
          r_blank_mask <= f_mask(ENTER_OP, 1'b0);
        end
        ENTER_OP: begin
          r_state      <= ENTER_A1;
          r_blank_mask <= f_mask(ENTER_A1, 1'b0);
        end
        ENTER_A1: begin
          r_a1           <= r_sw_s2;
          r_result_valid <= 1'b1;
          r_state        <= SHOW_RESULT;
          r_blank_mask   <= 6'b000000;
          if (!r_op_sub) begin
            r_res_mag <= w_sum;
            r_res_neg <= 1'b0;
          end else if (w_a0_ge) begin
            r_res_mag <= w_diff_fwd;
            r_res_neg <= 1'b0;
          end else begin
            r_res_mag <= w_diff_rev;
            r_res_neg <= 1'b1;
          end
        end
        SHOW_RESULT: begin
          r_a1           <= 4'd0;
          r_op_sub       <= 1'b0;
          r_res_mag      <= 5'd0;
          r_res_neg      <= 1'b0;
          r_result_valid <= 1'b0;
          r_state        <= ENTER_A0;
          r_blank_mask   <= f_mask(ENTER_A0, 1'b0);
        end
      endcase
    end else begin
      case (r_state)
        ENTER_A0:    r_a0     <= r_sw_s2;
        ENTER_OP:    r_op_sub <= r_op_s2;
        ENTER_A1:    r_a1     <= r_sw_s2;
        SHOW_RESULT: ;
      endcase
      if (r_blink_cnt == BL_W'(BLINK_DIV - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
        r_blank_mask  <= f_mask(r_state, ~r_blink_phase);
      end else begin
        r_blink_cnt <= r_blink_cnt + BL_W'(1);
      end
    end
  end

  assign a0           = r_a0;
  assign a1           = r_a1;
  assign op_sub       = r_op_sub;
  assign res_mag      = r_res_mag;
  assign res_neg      = r_res_neg;
  assign result_valid = r_result_valid;
  assign blank_mask   = r_blank_mask;
  assign state_o      = r_state;

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Testbench for calc_entry_sequencer: table-driven arithmetic vectors, hand
// sequences for reset, bounce, clear priority and blink, then random entry
// sequences checked against a step-level reference model.
module tb_calc_entry_sequencer;

  localparam int unsigned DB = 4;
  localparam int unsigned BD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       sw_op;
  logic       key_next_n;
  logic       key_clr_n;
  logic [3:0] a0, a1;
  logic       op_sub;
  logic [4:0] res_mag;
  logic       res_neg;
  logic       result_valid;
  logic [5:0] blank_mask;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  calc_entry_sequencer #(.DEBOUNCE_CYCLES(DB), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .sw(sw), .sw_op(sw_op),
    .key_next_n(key_next_n), .key_clr_n(key_clr_n),
    .a0(a0), .a1(a1), .op_sub(op_sub), .res_mag(res_mag), .res_neg(res_neg),
    .result_valid(result_valid), .blank_mask(blank_mask), .state_o(state_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: user-visible step state, updated once per completed key press
  int m_state, m_a0, m_a1, m_op, m_mag, m_neg, m_valid;

  typedef struct {
    logic [3:0] a0;
    logic       op;
    logic [3:0] a1;
    logic [4:0] mag;
    logic       neg;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press: held well past the debounce time, then released and settled
  task automatic press(input logic nxt, input logic clr);
    key_next_n = ~nxt;
    key_clr_n  = ~clr;
    idle(10);
    key_next_n = 1'b1;
    key_clr_n  = 1'b1;
    idle(10);
  endtask

  task model_reset();
    m_state = 0; m_a0 = 0; m_a1 = 0; m_op = 0; m_mag = 0; m_neg = 0; m_valid = 0;
  endtask

  task model_press(input logic nxt, input logic clr);
    int d;
    if (clr) begin
      model_reset();
    end else if (nxt) begin
      case (m_state)
        0: begin m_a0 = int'(sw); m_state = 1; end
        1: begin m_op = int'(sw_op); m_state = 2; end
        2: begin
          m_a1 = int'(sw);
          if (m_op == 0) begin
            m_mag = m_a0 + m_a1;
            m_neg = 0;
          end else begin
            d = m_a0 - m_a1;
            m_neg = (d < 0) ? 1 : 0;
            m_mag = (d < 0) ? -d : d;
          end
          m_valid = 1;
          m_state = 3;
        end
        default: begin
          m_a1 = 0; m_op = 0; m_mag = 0; m_neg = 0; m_valid = 0; m_state = 0;
        end
      endcase
    end
  endtask

  // Compare every output against the model; the field being edited tracks live switches
  task automatic check_all(input string tag);
    int exp_a0, exp_a1, exp_op, act_bit, exp_mask;
    exp_a0   = (m_state == 0) ? int'(sw) : m_a0;
    exp_op   = (m_state == 1) ? int'(sw_op) : m_op;
    exp_a1   = (m_state == 2) ? int'(sw) : m_a1;
    act_bit  = (m_state < 3) ? (1 << (5 - m_state)) : 0;
    exp_mask = (m_state < 3) ? 7 : 0;
    chk({tag, "_state"}, int'(state_o), m_state);
    chk({tag, "_a0"}, int'(a0), exp_a0);
    chk({tag, "_op"}, int'(op_sub), exp_op);
    chk({tag, "_a1"}, int'(a1), exp_a1);
    chk({tag, "_mag"}, int'(res_mag), m_mag);
    chk({tag, "_neg"}, int'(res_neg), m_neg);
    chk({tag, "_valid"}, int'(result_valid), m_valid);
    chk({tag, "_mask"}, int'(blank_mask) & ~act_bit, exp_mask);
  endtask

  initial begin
    int k;
    int r;
    vecs[0] = '{4'd9,  1'b0, 4'd7,  5'd16, 1'b0};
    vecs[1] = '{4'd3,  1'b1, 4'd12, 5'd9,  1'b1};
    vecs[2] = '{4'd4,  1'b1, 4'd4,  5'd0,  1'b0};
    vecs[3] = '{4'd15, 1'b0, 4'd15, 5'd30, 1'b0};
    vecs[4] = '{4'd0,  1'b1, 4'd15, 5'd15, 1'b1};
    vecs[5] = '{4'd15, 1'b1, 4'd0,  5'd15, 1'b0};
    vecs[6] = '{4'd8,  1'b0, 4'd0,  5'd8,  1'b0};
    vecs[7] = '{4'd0,  1'b0, 4'd0,  5'd0,  1'b0};

    rst = 1'b1; sw = 4'd0; sw_op = 1'b0; key_next_n = 1'b1; key_clr_n = 1'b1;
    model_reset();
    idle(3);
    chk("rst_state", int'(state_o), 0);
    chk("rst_mask", int'(blank_mask), 7);
    chk("rst_valid", int'(result_valid), 0);
    rst = 1'b0;
    idle(2);
    check_all("reset");

    // sw -> a0 takes three clock edges
    sw = 4'd5;
    idle(2);
    chk("sw_lat2_a0", int'(a0), 0);
    idle(1);
    chk("sw_lat3_a0", int'(a0), 5);

    // Arithmetic vectors through the full entry sequence
    for (int i = 0; i < 8; i++) begin
      sw = vecs[i].a0; idle(4);
      press(1'b1, 1'b0); model_press(1'b1, 1'b0);
      chk("vec_state_op", int'(state_o), 1);
      sw = 4'(~vecs[i].a0); sw_op = vecs[i].op; idle(4);
      chk("vec_a0_held", int'(a0), int'(vecs[i].a0));
      press(1'b1, 1'b0); model_press(1'b1, 1'b0);
      chk("vec_op_held", int'(op_sub), int'(vecs[i].op));
      sw = vecs[i].a1; sw_op = ~vecs[i].op; idle(4);
      press(1'b1, 1'b0); model_press(1'b1, 1'b0);
      chk("vec_mag", int'(res_mag), int'(vecs[i].mag));
      chk("vec_neg", int'(res_neg), int'(vecs[i].neg));
      chk("vec_valid", int'(result_valid), 1);
      chk("vec_mask", int'(blank_mask), 0);
      chk("vec_state_show", int'(state_o), 3);
      check_all("vec_show");
      press(1'b1, 1'b0); model_press(1'b1, 1'b0);
      chk("vec_back_state", int'(state_o), 0);
      chk("vec_back_valid", int'(result_valid), 0);
      chk("vec_back_mag", int'(res_mag), 0);
      check_all("vec_back");
    end

    // Bouncing press: only the final stable low counts, exactly once
    sw = 4'd6; idle(4);
    for (int i = 0; i < 10; i++) begin
      key_next_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      idle(2);
    end
    key_next_n = 1'b0; idle(10);
    key_next_n = 1'b1; idle(10);
    model_press(1'b1, 1'b0);
    chk("bounce_state", int'(state_o), 1);
    check_all("bounce");
    // Short glitch is rejected
    key_next_n = 1'b0; idle(3);
    key_next_n = 1'b1; idle(10);
    chk("glitch_state", int'(state_o), 1);
    check_all("glitch");

    // Clear and next together in ENTER_A1: clear wins
    sw_op = 1'b1; idle(4);
    press(1'b1, 1'b0); model_press(1'b1, 1'b0);
    sw = 4'd0; idle(4);
    chk("pre_clr_a0", int'(a0), 6);
    press(1'b1, 1'b1); model_press(1'b1, 1'b1);
    chk("clrnext_state", int'(state_o), 0);
    chk("clrnext_a0", int'(a0), 0);
    chk("clrnext_op", int'(op_sub), 0);
    check_all("clrnext");

    // Clear from SHOW_RESULT: valid and state drop on the same edge
    sw = 4'd11; idle(4); press(1'b1, 1'b0); model_press(1'b1, 1'b0);
    sw_op = 1'b1; idle(4); press(1'b1, 1'b0); model_press(1'b1, 1'b0);
    sw = 4'd2; idle(4); press(1'b1, 1'b0); model_press(1'b1, 1'b0);
    chk("show_mag", int'(res_mag), 9);
    check_all("show");
    key_clr_n = 1'b0;
    k = 0;
    while (result_valid && k < 20) begin
      @(negedge clk);
      k++;
      if (result_valid) chk("clr_state_held", int'(state_o), 3);
    end
    chk("clr_valid_drop", int'(result_valid), 0);
    chk("clr_drop_state", int'(state_o), 0);
    chk("clr_drop_mask", int'(blank_mask), 7);
    key_clr_n = 1'b1; idle(10);
    model_press(1'b0, 1'b1);
    check_all("clr_show");

    // Blink of HEX4 right after entering ENTER_OP
    key_next_n = 1'b0;
    k = 0;
    while (state_o != 2'd1 && k < 20) begin @(negedge clk); k++; end
    chk("blink_op_entry", int'(state_o), 1);
    for (int j = 0; j < 32; j++) begin
      if (j > 0) @(negedge clk);
      chk("blink_op_bit4", int'(blank_mask[4]), (j / 8) % 2);
      chk("blink_op_rest", int'(blank_mask & 6'b101111), 7);
    end
    key_next_n = 1'b1; idle(10);
    model_press(1'b1, 1'b0);
    // Blink of HEX3 after entering ENTER_A1
    key_next_n = 1'b0;
    k = 0;
    while (state_o != 2'd2 && k < 20) begin @(negedge clk); k++; end
    chk("blink_a1_entry", int'(state_o), 2);
    chk("blink_a1_bit4", int'(blank_mask[4]), 0);
    for (int j = 0; j < 16; j++) begin
      if (j > 0) @(negedge clk);
      chk("blink_a1_bit3", int'(blank_mask[3]), (j / 8) % 2);
    end
    key_next_n = 1'b1; idle(10);
    model_press(1'b1, 1'b0);
    check_all("blink_done");

    // Random entry sequences against the model
    for (int it = 0; it < 60; it++) begin
      r = int'($urandom_range(9));
      if (r < 3) begin
        sw = 4'($urandom_range(15));
        sw_op = 1'($urandom_range(1));
        idle(4);
        check_all("rnd_sw");
      end else if (r < 8) begin
        press(1'b1, 1'b0); model_press(1'b1, 1'b0);
        check_all("rnd_next");
      end else if (r < 9) begin
        press(1'b0, 1'b1); model_press(1'b0, 1'b1);
        check_all("rnd_clr");
      end else begin
        press(1'b1, 1'b1); model_press(1'b1, 1'b1);
        check_all("rnd_both");
      end
    end

    // Reset mid-debounce: clears everything and leaves no pending event
    key_next_n = 1'b0; idle(3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", int'(state_o), 0);
    chk("async_rst_valid", int'(result_valid), 0);
    chk("async_rst_mask", int'(blank_mask), 7);
    key_next_n = 1'b1;
    idle(2);
    rst = 1'b0;
    model_reset();
    idle(12);
    check_all("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/calc_entry_sequencer.md
# calc_entry_sequencer

Sequencing controller for the two-operand 4-bit add/subtract display path (HEX5 = A0, HEX4 = op, HEX3 = A1, HEX2..0 = "=", sign, result). It takes slide-switch operand/op entry and a "next" pushbutton, and steps the user through A0 → op → A1 → result. It drives registered operand, op and result values plus a per-digit blank mask that blinks the field being edited. It sits between the board I/O and the seven-segment display logic.

## Interface

Parameters:
- DEBOUNCE_CYCLES, default 500000: cycles a synchronized key level must be stable before it is accepted (10 ms at 50 MHz).
- BLINK_DIV, default 12500000: cycles per blink half-period (0.25 s at 50 MHz).

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- sw  input  4  operand entry switches, asynchronous to clk.
- sw_op  input  1  op select: 0 = add, 1 = subtract. Asynchronous to clk.
- key_next_n  input  1  "next" pushbutton, active-low, bouncing, asynchronous.
- key_clr_n  input  1  "clear" pushbutton, active-low, bouncing, asynchronous.
- a0  output  4  operand A0 for HEX5.
- a1  output  4  operand A1 for HEX3.
- op_sub  output  1  current op for HEX4.
- res_mag  output  5  result magnitude, 0..30.
- res_neg  output  1  result sign; 1 = negative.
- result_valid  output  1  high only in SHOW_RESULT.
- blank_mask  output  6  bit i = 1 blanks HEXi.
- state_o  output  2  current state encoding, for debug LEDs.

## Operation

Input conditioning (identical for each key):
- Synchronize through 2 flops.
- Debounce with a counter that reloads on any level change. Accept the new level after DEBOUNCE_CYCLES consecutive equal samples.
- A press event is a 1-cycle pulse on the accepted level's 1→0 transition. Release generates nothing.
- sw and sw_op pass through a 2-flop synchronizer only; there is no debounce.

State machine (state_o encoding):
- ENTER_A0 (0):
  - a0 follows synced sw every cycle.
  - A next press holds a0 and moves to ENTER_OP.
- ENTER_OP (1):
  - op_sub follows synced sw_op.
  - A next press holds op_sub and moves to ENTER_A1.
- ENTER_A1 (2):
  - a1 follows synced sw.
  - A next press holds a1, registers the result, sets result_valid and moves to SHOW_RESULT.
- SHOW_RESULT (3):
  - All values are frozen.
  - A next press clears a1, op_sub, res_mag, res_neg and result_valid, and moves to ENTER_A0. a0 resumes following sw.

Clear:
- A clear press in any state forces ENTER_A0 and zeroes a0, a1, op_sub, res_mag, res_neg and result_valid.
- Clear and next pressed in the same cycle: clear wins.

Arithmetic (registered at the ENTER_A1 → SHOW_RESULT transition, using held a0/op_sub and the a1 being latched):
- Add: res_mag = {1'b0,a0} + {1'b0,a1} (0..30), res_neg = 0.
- Subtract:
  - If a0 ≥ a1: res_mag = a0 − a1, res_neg = 0.
  - Otherwise: res_mag = a1 − a0, res_neg = 1.
- Zero result always has res_neg = 0.

Blink:
- blink_phase toggles every BLINK_DIV cycles.
- The blink counter and phase reset to 0 on every state change, so the new field is visible immediately.
- The active field's mask bit equals blink_phase:
  - ENTER_A0 → bit 5.
  - ENTER_OP → bit 4.
  - ENTER_A1 → bit 3.
  - SHOW_RESULT → none.
- In ENTER_*, result digits HEX2..0 are blanked (mask bits 2..0 = 1). In SHOW_RESULT, blank_mask = 0.

Reset values: state ENTER_A0; a0, a1, op_sub, res_mag, res_neg and result_valid all 0; blank_mask = 6'b000111; debounced levels 1 (released); all counters 0.

## Timing

- sw → a0/a1 (in the live state): 3 cycles (2 sync + 1 register).
- Key press latency: accepted press pulse after 2 sync cycles + DEBOUNCE_CYCLES stable cycles. State, latched values and the result update on the clock edge after the pulse.
- A held key produces exactly one event. Bounce shorter than DEBOUNCE_CYCLES produces none.
- rst asserted mid-debounce or mid-state clears everything asynchronously. After release, no event is generated until a fresh, debounced press.
- All outputs are registered. There are no combinational paths from input to output.

## Test plan

Bench uses DEBOUNCE_CYCLES = 4 and BLINK_DIV = 8.

- Reset check: after reset, state 0, all value outputs 0, blank_mask 000111. Set sw = 5 → a0 = 5 three cycles later.
- Add sequence:
  - sw = 9, press next → a0 held at 9.
  - sw_op = 0, press next.
  - sw = 7, press next → res_mag = 16, res_neg = 0, result_valid = 1, blank_mask = 0.
- Subtract negative: a0 = 3, op = sub, a1 = 12 → res_mag = 9, res_neg = 1. Also a0 = 4, a1 = 4 → res_mag = 0, res_neg = 0.
- Bounce rejection:
  - key_next_n toggles every 2 cycles for 20 cycles, then stays low → exactly one state advance.
  - A 3-cycle low glitch → no advance.
- Clear priority: in ENTER_A1, press clear and next in the same cycle → state 0, all values 0. In SHOW_RESULT, press clear → result_valid drops on the next edge.
- Blink: in ENTER_OP, blank_mask[4] is 0 for 8 cycles after entry, then 1 for 8, repeating. After the next press, blank_mask[4] = 0 and blank_mask[3] starts at 0.
